// File: rtl/csc_mat_expand_if.sv
// Descriptor-in / entry-out bundle for csc_mat_expand.
// The slave modport is the expander's view; the master modport is the generator/consumer side.
interface csc_mat_expand_if #(
    parameter int IDX_W = 8,
    parameter int VAL_W = 32
);
    logic [4*IDX_W-1:0] s_col_index;
    logic [3:0]         s_nz_mask;
    logic [4*VAL_W-1:0] s_val_i;
    logic [4*VAL_W-1:0] s_val_r;
    logic               s_vld;
    logic               s_rdy;
    logic [IDX_W-1:0]   m_row;
    logic [IDX_W-1:0]   m_col;
    logic [VAL_W-1:0]   m_val_i;
    logic [VAL_W-1:0]   m_val_r;
    logic               m_last_col;
    logic               m_last;
    logic               m_vld;
    logic               m_rdy;
    logic               busy;

    modport master (
        output s_col_index, s_nz_mask, s_val_i, s_val_r, s_vld, m_rdy,
        input  s_rdy, m_row, m_col, m_val_i, m_val_r, m_last_col, m_last, m_vld, busy
    );

    modport slave (
        input  s_col_index, s_nz_mask, s_val_i, s_val_r, s_vld, m_rdy,
        output s_rdy, m_row, m_col, m_val_i, m_val_r, m_last_col, m_last, m_vld, busy
    );
endinterface

// File: rtl/csc_mat_expand.sv
// Expands a circulant sparse-matrix descriptor into a column-major (row, col, value) stream.
//   state | meaning
//   IDLE  | s_rdy high, waiting for a descriptor; a zero mask is consumed silently
//   EMIT  | output register holds the current entry; advances on m_vld & m_rdy
module csc_mat_expand #(
    parameter int SUBCAR_NUM   = 16,
    parameter int OFDM_SYM_NUM = 16,
    parameter int MAT_RANK     = SUBCAR_NUM * OFDM_SYM_NUM,
    parameter int IDX_W        = $clog2(MAT_RANK),
    parameter int VAL_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    csc_mat_expand_if.slave  bus
);

    if (MAT_RANK < 2 || (MAT_RANK & (MAT_RANK - 1)) != 0) begin : g_rank_chk
        $error("csc_mat_expand: MAT_RANK must be a power of two");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx_q [4];
    logic [VAL_W-1:0]   vr_q  [4];
    logic [VAL_W-1:0]   vi_q  [4];
    logic [3:0]         mask_q;
    logic [1:0]         slot_q;

    logic [IDX_W-1:0]   src_idx [4];
    logic [VAL_W-1:0]   src_vr  [4];
    logic [VAL_W-1:0]   src_vi  [4];
    logic [3:0]         src_mask;
    logic [3:0]         higher;
    logic [1:0]         nxt_slot;
    logic [IDX_W-1:0]   nxt_col;
    logic [IDX_W-1:0]   nxt_row;
    logic               nxt_last_col;
    logic               nxt_last;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [3:0] above(input logic [1:0] k);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) r[j] = (j > int'(k));
        return r;
    endfunction

    // In IDLE the first entry is built straight from the inputs so it appears one cycle after the handshake.
    always_comb begin
        src_mask = (state == IDLE) ? bus.s_nz_mask : mask_q;
        for (int k = 0; k < 4; k++) begin
            src_idx[k] = (state == IDLE) ? bus.s_col_index[k*IDX_W +: IDX_W] : idx_q[k];
            src_vr[k]  = (state == IDLE) ? bus.s_val_r[k*VAL_W +: VAL_W]     : vr_q[k];
            src_vi[k]  = (state == IDLE) ? bus.s_val_i[k*VAL_W +: VAL_W]     : vi_q[k];
        end
        higher = mask_q & above(slot_q);
        if (state == IDLE) begin
            nxt_col  = '0;
            nxt_slot = lowest(src_mask);
        end else if (higher != 4'b0) begin
            nxt_col  = bus.m_col;
            nxt_slot = lowest(higher);
        end else begin
            nxt_col  = bus.m_col + 1'b1;
            nxt_slot = lowest(mask_q);
        end
        nxt_row      = nxt_col - src_idx[nxt_slot];
        nxt_last_col = (src_mask & above(nxt_slot)) == 4'b0;
        nxt_last     = nxt_last_col && (&nxt_col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mask_q         <= '0;
            slot_q         <= '0;
            for (int k = 0; k < 4; k++) begin
                idx_q[k] <= '0;
                vr_q[k]  <= '0;
                vi_q[k]  <= '0;
            end
            bus.s_rdy      <= 1'b1;
            bus.busy       <= 1'b0;
            bus.m_vld      <= 1'b0;
            bus.m_row      <= '0;
            bus.m_col      <= '0;
            bus.m_val_r    <= '0;
            bus.m_val_i    <= '0;
            bus.m_last_col <= 1'b0;
            bus.m_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_vld) begin
                        mask_q <= bus.s_nz_mask;
                        for (int k = 0; k < 4; k++) begin
                            idx_q[k] <= src_idx[k];
                            vr_q[k]  <= src_vr[k];
                            vi_q[k]  <= src_vi[k];
                        end
                        if (bus.s_nz_mask != 4'b0) begin
                            state          <= EMIT;
                            bus.s_rdy      <= 1'b0;
                            bus.busy       <= 1'b1;
                            bus.m_vld      <= 1'b1;
                            slot_q         <= nxt_slot;
                            bus.m_col      <= nxt_col;
                            bus.m_row      <= nxt_row;
                            bus.m_val_r    <= src_vr[nxt_slot];
                            bus.m_val_i    <= src_vi[nxt_slot];
                            bus.m_last_col <= nxt_last_col;
                            bus.m_last     <= nxt_last;
                        end
                    end
                end
                EMIT: begin
                    if (bus.m_vld && bus.m_rdy) begin
                        if (bus.m_last) begin
                            state     <= IDLE;
                            bus.m_vld <= 1'b0;
                            bus.busy  <= 1'b0;
                            bus.s_rdy <= 1'b1;
                        end else begin
                            slot_q         <= nxt_slot;
                            bus.m_col      <= nxt_col;
                            bus.m_row      <= nxt_row;
                            bus.m_val_r    <= src_vr[nxt_slot];
                            bus.m_val_i    <= src_vi[nxt_slot];
                            bus.m_last_col <= nxt_last_col;
                            bus.m_last     <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csc_mat_expand.sv
// Directed bench for csc_mat_expand: an 8x8 instance driven from a vector table plus
// a default-size (256) instance for the wide-index case.
module tb_csc_mat_expand;

    localparam int R  = 8;
    localparam int IW = 3;
    localparam logic [127:0] VR = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] VI = {32'h13, 32'h12, 32'h11, 32'h10};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    csc_mat_expand_if #(.IDX_W(IW), .VAL_W(32)) bus ();
    csc_mat_expand_if #(.IDX_W(8),  .VAL_W(32)) bb ();

    csc_mat_expand #(.SUBCAR_NUM(2), .OFDM_SYM_NUM(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    csc_mat_expand u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bb)
    );

    typedef struct packed {
        logic [2:0]  row;
        logic [2:0]  col;
        logic [31:0] vr;
        logic [31:0] vi;
        logic        lc;
        logic        l;
    } ent_t;

    typedef struct {
        logic [3:0]  mask;
        logic [11:0] idx;
        bit          rnd;
        int          exp_n;
        logic [2:0]  r0;
        logic [2:0]  r1;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Entry n of the expansion: column n/popcount, then the (n%popcount)-th set slot.
    function automatic ent_t model(input logic [3:0] mask, input logic [11:0] idx, input int n);
        ent_t e;
        int pc, col, j, cnt, sel;
        pc  = $countones(mask);
        col = n / pc;
        j   = n % pc;
        cnt = 0;
        sel = 0;
        for (int k = 0; k < 4; k++)
            if (mask[k]) begin
                if (cnt == j) sel = k;
                cnt++;
            end
        e.col = col[2:0];
        e.row = 3'(col - int'(idx[sel*3 +: 3]));
        e.vr  = 32'(sel + 1);
        e.vi  = 32'(32'h10 + sel);
        e.lc  = (j == pc - 1);
        e.l   = (j == pc - 1) && (col == R - 1);
        return e;
    endfunction

    task automatic send(input logic [3:0] mask, input logic [11:0] idx);
        @(negedge clk);
        bus.s_nz_mask   = mask;
        bus.s_col_index = idx;
        bus.s_val_r     = VR;
        bus.s_val_i     = VI;
        bus.s_vld       = 1'b1;
        chk("s_rdy_at_send", bus.s_rdy, 1);
        @(posedge clk);
        #1;
        bus.s_vld       = 1'b0;
        bus.s_col_index = ~idx;
        bus.s_val_r     = '1;
        bus.s_val_i     = '0;
    endtask

    task automatic run_vec(input logic [3:0] mask, input logic [11:0] idx, input bit rnd,
                           input int exp_n, input logic [2:0] r0, input logic [2:0] r1);
        int n, cyc, bubbles;
        bit done, stall;
        ent_t got, prev, exp;
        logic [2:0] g0, g1;
        n = 0; cyc = 0; bubbles = 0; done = 0; stall = 0; g0 = '0; g1 = '0; prev = '0;
        send(mask, idx);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            got = {bus.m_row, bus.m_col, bus.m_val_r, bus.m_val_i, bus.m_last_col, bus.m_last};
            if (cyc == 1) chk("first_latency_vld", bus.m_vld, 1);
            if (stall) chk("hold_under_stall", got, prev);
            if (!bus.m_vld) bubbles++;
            bus.m_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && n >= 5 && n < 8) begin
                bus.s_vld = 1'b1;
                chk("s_rdy_low_in_emit", bus.s_rdy, 0);
            end else begin
                bus.s_vld = 1'b0;
            end
            if (bus.m_vld && bus.m_rdy) begin
                exp = model(mask, idx, n);
                chk($sformatf("entry%0d", n), got, exp);
                if (n == 0) g0 = bus.m_row;
                if (n == 1) g1 = bus.m_row;
                n++;
                if (bus.m_last) done = 1;
            end
            stall = bus.m_vld && !bus.m_rdy;
            prev  = got;
        end
        bus.s_vld = 1'b0;
        bus.m_rdy = 1'b1;
        chk("finished_in_budget", done, 1);
        chk("entry_count", n, exp_n);
        chk("no_bubbles", bubbles, 0);
        chk("row_first", g0, r0);
        chk("row_second", g1, r1);
        @(negedge clk);
        chk("idle_after_last", {bus.m_vld, bus.s_rdy, bus.busy}, 3'b010);
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        int n, cyc;
        bit done;
        logic [7:0] b_r0, b_r1, b_lr, b_lc;

        vecs[0] = '{4'b0011, {3'd0, 3'd0, 3'd4, 3'd0}, 1'b0, 16, 3'd0, 3'd4};
        vecs[1] = '{4'b1010, {3'd7, 3'd0, 3'd2, 3'd0}, 1'b0, 16, 3'd6, 3'd1};
        vecs[2] = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1, 32, 3'd0, 3'd7};
        vecs[3] = '{4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, 1'b0,  8, 3'd1, 3'd2};
        vecs[4] = '{4'b0110, {3'd0, 3'd5, 3'd5, 3'd0}, 1'b0, 16, 3'd3, 3'd3};
        vecs[5] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 1'b0,  8, 3'd0, 3'd1};

        bus.s_col_index = '0; bus.s_nz_mask = '0; bus.s_val_r = '0; bus.s_val_i = '0;
        bus.s_vld = 1'b0; bus.m_rdy = 1'b1;
        bb.s_col_index = '0; bb.s_nz_mask = '0; bb.s_val_r = '0; bb.s_val_i = '0;
        bb.s_vld = 1'b0; bb.m_rdy = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_ctrl", {bus.s_rdy, bus.m_vld, bus.busy}, 3'b100);
        chk("reset_data", {bus.m_row, bus.m_col, bus.m_val_r, bus.m_val_i, bus.m_last_col, bus.m_last}, 0);
        rst_n = 1'b1;

        // Zero mask is swallowed without output.
        send(4'b0000, 12'h0);
        ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (bus.m_vld !== 1'b0 || bus.s_rdy !== 1'b1) ok = 0;
        end
        chk("mask0_no_output", ok, 1);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i].mask, vecs[i].idx, vecs[i].rnd, vecs[i].exp_n, vecs[i].r0, vecs[i].r1);

        // Reset after five consumed entries aborts the matrix.
        send(4'b0011, {3'd0, 3'd0, 3'd4, 3'd0});
        bus.m_rdy = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_vld_before_rst", bus.m_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_ctrl", {bus.m_vld, bus.s_rdy, bus.busy}, 3'b010);
        chk("rst_abort_col", bus.m_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b0, 8, 3'd5, 3'd6);

        // Default-size instance.
        @(negedge clk);
        bb.s_nz_mask   = 4'b0101;
        bb.s_col_index = {8'd0, 8'd128, 8'd0, 8'd255};
        bb.s_val_r     = VR;
        bb.s_val_i     = VI;
        bb.s_vld       = 1'b1;
        @(posedge clk);
        #1;
        bb.s_vld = 1'b0;
        n = 0; cyc = 0; done = 0;
        b_r0 = '0; b_r1 = '0; b_lr = '0; b_lc = '0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bb.m_vld && bb.m_rdy) begin
                if (n == 0) b_r0 = bb.m_row;
                if (n == 1) b_r1 = bb.m_row;
                n++;
                if (bb.m_last) begin
                    done = 1;
                    b_lr = bb.m_row;
                    b_lc = bb.m_col;
                end
            end
        end
        chk("big_finished", done, 1);
        chk("big_count", n, 512);
        chk("big_row_first", b_r0, 8'd1);
        chk("big_row_second", b_r1, 8'd128);
        chk("big_last_col", b_lc, 8'd255);
        chk("big_last_row", b_lr, 8'd127);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csc_mat_expand.md
Name: csc_mat_expand

Overview:
- Consumer/decoder for the compressed sparse-matrix descriptor produced by the matrix generator.
- The descriptor is a circulant matrix: the first-row nonzero column positions plus up to 4 complex nonzero values. Row n is the first row circularly shifted right by n.
- The block expands the descriptor into a column-major (CSC-order) stream of (row, col, value) entries.
- It sits between the matrix generator and the downstream matrix-multiply datapath.

Parameters:
- SUBCAR_NUM, 16, number of subcarriers.
- OFDM_SYM_NUM, 16, number of OFDM symbols.
- MAT_RANK, SUBCAR_NUM*OFDM_SYM_NUM, matrix dimension. Must be a power of two; elaboration fails otherwise.
- IDX_W, $clog2(MAT_RANK), index width.
- VAL_W, 32, width of each real/imag value.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_col_index  in  4*IDX_W  first-row column index of slot k in bits [k*IDX_W +: IDX_W]
- s_nz_mask  in  4  bit k=1: slot k holds a nonzero
- s_val_i  in  4*VAL_W  imag part of slot k in [k*VAL_W +: VAL_W]
- s_val_r  in  4*VAL_W  real part of slot k
- s_vld  in  1  descriptor valid
- s_rdy  out  1  block ready for a descriptor
- m_row  out  IDX_W  row of the emitted entry
- m_col  out  IDX_W  column of the emitted entry
- m_val_i  out  VAL_W  imag value
- m_val_r  out  VAL_W  real value
- m_last_col  out  1  last entry of the current column
- m_last  out  1  last entry of the matrix
- m_vld  out  1  entry valid
- m_rdy  in  1  downstream accepts the entry
- busy  out  1  expansion in progress

Behaviour:
- Reset (async, rst_n low): state IDLE; s_rdy=1; m_vld=0; busy=0; m_row, m_col, m_val_i, m_val_r, m_last_col, m_last all 0. Reset asserted mid-expansion aborts immediately; the partial matrix is dropped.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - s_rdy=1.
  - On s_vld&s_rdy: latch index, mask and values.
  - If mask!=0: col_cnt=0, slot=lowest set mask bit, go to EMIT, s_rdy=0, busy=1.
  - If mask==0: descriptor is consumed, no output, remain IDLE.
- EMIT:
  - The output register holds the current entry: m_col=col_cnt, m_row=(col_cnt - idx[slot]) mod MAT_RANK (IDX_W truncating subtract), m_val=val[slot].
  - First m_vld=1 appears the cycle after the input handshake (1-cycle latency).
  - Handshake is AXI-style: while m_vld&!m_rdy, all m_* outputs hold stable. On m_vld&m_rdy the next entry loads in the same edge, giving 1 entry/cycle with no bubbles.
- Iteration order:
  - Columns run 0..MAT_RANK-1.
  - Within a column, set slots run in ascending k. Unset slots are skipped via a priority encoder, with no idle cycles.
  - m_last_col=1 on the highest set slot of each column.
  - m_last=1 on the highest set slot of column MAT_RANK-1.
- Total entries per descriptor = popcount(mask)*MAT_RANK.
- On handshake of the m_last entry: m_vld=0, busy=0, state IDLE, s_rdy=1 in the following cycle. New-descriptor acceptance never overlaps output.
- Duplicate indices in two set slots: both entries are emitted, not merged.
- Indices wrap naturally mod MAT_RANK. Row arithmetic uses IDX_W bits only.
- s_vld during EMIT is ignored (s_rdy=0). Input data need not stay stable after acceptance.
- Values pass through unmodified. There is no arithmetic on values.

Test Plan:
- Use SUBCAR_NUM=2, OFDM_SYM_NUM=4 (MAT_RANK=8) unless noted.
- Basic: mask=4'b0011, idx0=0, idx1=4, val_r0=1, val_r1=2, m_rdy=1 -> 16 entries on consecutive cycles starting 1 cycle after the handshake. Column 0 gives (row0, val1) then (row4, val2). Column 3 gives row3 then row7. m_last on entry 16. s_rdy rises the cycle after.
- Sparse mask: mask=4'b1010, idx1=2, idx3=7 -> column 0 gives rows 6 and 1. Slots 0 and 2 are never emitted, with no bubbles. m_last_col asserts on the slot-3 entries only.
- Backpressure: mask=4'hF with m_rdy toggling randomly -> m_* stable whenever m_vld&!m_rdy. Exactly 32 entries in the correct order. s_vld pulsed during EMIT is not accepted.
- Edge masks: mask=0 -> consumed, no m_vld, s_rdy stays 1. Then mask=4'b1000, idx3=7 -> 8 entries with row=(col-7) mod 8, i.e. 1,2,...,7,0. m_last_col and m_last both set on the 8th entry.
- Reset mid-operation: assert rst_n low after 5 entries -> m_vld=0 and s_rdy=1 immediately. A new descriptor after release expands from column 0.
- Default params (MAT_RANK=256): mask=4'b0101, idx0=255, idx2=128 -> 512 entries. Column 0 gives rows 1 and 128. Final entry is col 255, row 127, with m_last=1.
